tft_cmd_queue: RTL and testbench
================================

// Module: tft_cmd_queue
// PURPOSE
//  Command front-end for the ILI9341 TFT controller: buffers rectangle-fill and init commands from
//  the capture/UI logic in a FIFO and sequences them into the controller's init/draw pulse + busy
//  handshake. Holds draw parameters stable for the whole transaction. Normalises and clips
//  coordinates. Issues the screen init sequence automatically after reset.
// PARAMETERS
//  DEPTH_LOG2  4    queue depth = 2**DEPTH_LOG2 entries
//  BOOT_INIT   1    1 = issue one INIT command automatically after reset
//  XMAX        239  last valid column; x clipped to [0,XMAX]
//  YMAX        319  last valid row; y clipped to [0,YMAX]
//  RISE_TMO    7    cycles to wait for tft_busy to rise after a pulse before flagging err
// PORTS
//  clk          in   1   system clock
//  rstn         in   1   synchronous active-low reset
//  cmd_valid    in   1   command present
//  cmd_ready    out  1   queue not full; push occurs when cmd_valid & cmd_ready
//  cmd_op       in   1   0 = FILL rectangle, 1 = INIT screen
//  cmd_color    in   16  rrrrrggggggbbbbb fill colour
//  cmd_x0/x1    in   16  column corners, any order
//  cmd_y0/y1    in   16  row corners, any order
//  tft_init     out  1   one-cycle init pulse to controller
//  tft_draw     out  1   one-cycle draw pulse to controller
//  tft_color    out  16  registered colour, stable ISSUE..WAIT_FALL
//  tft_xstart/xend/ystart/yend  out 16 each  registered window, stable ISSUE..WAIT_FALL
//  tft_busy     in   1   controller busy
//  q_level      out  DEPTH_LOG2+1  entries in queue
//  idle         out  1   queue empty and sequencer in IDLE
//  err          out  1   sticky: busy failed to rise within RISE_TMO; cleared only by reset
// BEHAVIOUR
//  Reset values: cmd_ready=0 during reset, tft_init=tft_draw=0, tft_* params=0, q_level=0, idle=0, err=0.
//  Push normalisation (combinational, before FIFO write): x_lo=min(x0,x1), x_hi=max(x0,x1), same for y;
//   each then clipped to XMAX/YMAX (unsigned compare). INIT entries store op only; other fields ignored.
//  FIFO: cmd_ready = !full. Push when full is impossible (ready low). Pop happens only in IDLE.
//  States:
//   FLUSH  - entered on reset. Waits for tft_busy==0; the controller has no reset and may be mid-transfer.
//            Then -> BOOT if BOOT_INIT, else -> IDLE.
//   BOOT   - loads an INIT op as the current command, -> ISSUE.
//   IDLE   - if !empty & !tft_busy: pop head into param regs, -> ISSUE. idle=1 iff empty here.
//   ISSUE  - tft_draw (FILL) or tft_init (INIT) = 1 for exactly this cycle; timer cleared; -> WAIT_RISE.
//   WAIT_RISE - tft_busy==1 -> WAIT_FALL. Else timer++; timer==RISE_TMO -> err<=1, -> IDLE.
//   WAIT_FALL - tft_busy==0 -> IDLE.
//  Latency: command accepted at edge N into an empty queue, sequencer in IDLE -> param regs and
//   tft_draw valid in cycle N+2; controller busy is expected at N+4.
//  Throughput: one command per controller transaction plus 3 cycles of overhead.
//  Param regs change only on the pop edge. They are never altered in ISSUE, WAIT_RISE or WAIT_FALL,
//   because the controller samples them throughout the fill.
//  Simultaneous push and pop in IDLE: both occur and q_level is unchanged.
//  Push while sequencer busy: queued normally.
//  Reset mid-operation: FIFO emptied, pulses deasserted, -> FLUSH. No pulse is issued until tft_busy is low.
//  Degenerate 1x1 rect (x0==x1, y0==y1) is passed through unchanged.
// STRUCTURE
//  Shared include tft_defs.vi: OP_FILL/OP_INIT codes, SCREEN_XMAX/YMAX, CMD_W=81 (op + colour + 4x16),
//   state encodings.
//  Sub-module tft_cmd_fifo: synchronous single-clock FIFO, parameterised width/depth, with level output.
//  Top holds normaliser/clipper, param regs, sequencer FSM and timeout counter.
// TESTING (bench models tft_ctrl busy: rises 2 cycles after pulse, lasts L cycles)
//  1. Reset with BOOT_INIT=1, busy=0 -> exactly one tft_init pulse 2 cycles after rstn rises;
//     idle=1 after busy falls.
//  2. Push FILL color=16'hF800, x0=10,x1=20,y0=5,y1=7 -> one tft_draw with xstart=10,xend=20,ystart=5,
//     yend=7; params constant until busy falls.
//  3. Push x0=300,x1=50,y0=400,y1=0 -> xstart=50, xend=239, ystart=0, yend=319.
//  4. Hold busy high via a long L and push 17 commands (DEPTH_LOG2=4) -> cmd_ready=0 at q_level=16.
//     Drain -> 16 draws in order, colours match push order.
//  5. Assert rstn=0 during WAIT_FALL with busy held high 50 more cycles -> no pulse until busy low,
//     then one boot tft_init.
//  6. Bench never raises busy after a draw -> err=1 after RISE_TMO cycles; next queued command still issues.

Source files
------------

// File: rtl/tft_cmd_queue_pkg.sv
// Shared definitions for the TFT command queue: opcodes, screen limits,
// queue entry layout, sequencer states and small coordinate helpers.
package tft_cmd_queue_pkg;

    localparam logic OP_FILL     = 1'b0;
    localparam logic OP_INIT     = 1'b1;
    localparam int   SCREEN_XMAX = 239;
    localparam int   SCREEN_YMAX = 319;
    localparam int   CMD_W       = 81;   // op + colour + 4 x 16-bit corners

    typedef enum logic [2:0] {
        ST_FLUSH     = 3'd0,
        ST_BOOT      = 3'd1,
        ST_IDLE      = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_RISE = 3'd4,
        ST_WAIT_FALL = 3'd5
    } state_t;

    // One queue entry; corners are already normalised and clipped.
    typedef struct packed {
        logic        op;
        logic [15:0] color;
        logic [15:0] xlo;
        logic [15:0] xhi;
        logic [15:0] ylo;
        logic [15:0] yhi;
    } cmd_t;

    function automatic logic [15:0] umin(input logic [15:0] a, input logic [15:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [15:0] umax(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [15:0] clip(input logic [15:0] v, input logic [15:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/tft_cmd_queue_if.sv
// Command push bus into the TFT command queue.
//   valid/ready : push handshake, transfer when both high
//   op          : 0 = FILL rectangle, 1 = INIT screen
//   color       : rrrrrggggggbbbbb fill colour
//   x0/x1/y0/y1 : rectangle corners, any order
interface tft_cmd_queue_if;
    logic        valid;
    logic        ready;
    logic        op;
    logic [15:0] color;
    logic [15:0] x0;
    logic [15:0] x1;
    logic [15:0] y0;
    logic [15:0] y1;

    modport master (output valid, op, color, x0, x1, y0, y1, input ready);
    modport slave  (input valid, op, color, x0, x1, y0, y1, output ready);
endinterface

// File: rtl/tft_cmd_queue_fifo.sv
// Single-clock synchronous FIFO with occupancy output.
//   i_clk/i_rstn : clock, synchronous active-low reset (empties the FIFO)
//   i_push/i_wdata : write strobe and data (ignored when full)
//   i_pop        : advance head (ignored when empty)
//   o_rdata      : head entry, valid while !o_empty
//   o_full/o_empty/o_level : occupancy status
module tft_cmd_queue_fifo #(
    parameter int W  = 81,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic [W-1:0]  o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_level
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(1 << AW);

    logic [W-1:0]  r_mem [0:(1<<AW)-1];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_level == FULL_LVL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    // Storage needs no reset: only entries covered by r_level are ever read.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end
endmodule

// File: rtl/tft_cmd_queue.sv
// Command front-end for the ILI9341 TFT controller. Normalises and clips
// pushed rectangles, buffers them, and sequences one init/draw pulse per
// command against the controller busy handshake. Draw parameters are held
// from ISSUE until busy falls. One INIT is issued after reset (BOOT_INIT).
//   i_clk/i_rstn : clock, synchronous active-low reset
//   cmd          : push bus (slave side)
//   o_tft_init/o_tft_draw : one-cycle pulses to the controller
//   o_tft_color/xstart/xend/ystart/yend : registered draw parameters
//   i_tft_busy   : controller busy
//   o_q_level    : queue occupancy
//   o_idle       : queue empty and sequencer idle
//   o_err        : sticky, busy failed to rise after a pulse
module tft_cmd_queue
    import tft_cmd_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int BOOT_INIT  = 1,
    parameter int XMAX       = SCREEN_XMAX,
    parameter int YMAX       = SCREEN_YMAX,
    parameter int RISE_TMO   = 7
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    tft_cmd_queue_if.slave        cmd,
    output logic                  o_tft_init,
    output logic                  o_tft_draw,
    output logic [15:0]           o_tft_color,
    output logic [15:0]           o_tft_xstart,
    output logic [15:0]           o_tft_xend,
    output logic [15:0]           o_tft_ystart,
    output logic [15:0]           o_tft_yend,
    input  logic                  i_tft_busy,
    output logic [DEPTH_LOG2:0]   o_q_level,
    output logic                  o_idle,
    output logic                  o_err
);
    localparam int TW = (RISE_TMO < 2) ? 1 : $clog2(RISE_TMO + 1);

    cmd_t          w_wr;
    cmd_t          w_head;
    cmd_t          r_cmd;
    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_boot;
    logic          w_err_set;
    logic [TW-1:0] r_tmr;
    logic [TW-1:0] w_tmr_nxt;
    logic          r_err;

    assign cmd.ready = i_rstn & ~w_full;
    assign w_push    = cmd.valid & cmd.ready;
    assign w_tmr_nxt = r_tmr + TW'(1);

    // INIT entries carry only the opcode so a later pop leaves clean params.
    always_comb begin
        w_wr    = '0;
        w_wr.op = cmd.op;
        if (cmd.op == OP_FILL) begin
            w_wr.color = cmd.color;
            w_wr.xlo   = clip(umin(cmd.x0, cmd.x1), 16'(XMAX));
            w_wr.xhi   = clip(umax(cmd.x0, cmd.x1), 16'(XMAX));
            w_wr.ylo   = clip(umin(cmd.y0, cmd.y1), 16'(YMAX));
            w_wr.yhi   = clip(umax(cmd.y0, cmd.y1), 16'(YMAX));
        end
    end

    tft_cmd_queue_fifo #(.W(CMD_W), .AW(DEPTH_LOG2)) u_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (w_push),
        .i_wdata (w_wr),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_q_level)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= ST_FLUSH;
            r_cmd   <= '0;
            r_tmr   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Params move only here; the controller samples them during the fill.
            if (w_pop)       r_cmd    <= w_head;
            else if (w_boot) r_cmd.op <= OP_INIT;
            if (r_state == ST_ISSUE)          r_tmr <= '0;
            else if (r_state == ST_WAIT_RISE) r_tmr <= w_tmr_nxt;
            if (w_err_set) r_err <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_boot      = 1'b0;
        w_err_set   = 1'b0;
        o_tft_init  = 1'b0;
        o_tft_draw  = 1'b0;
        case (r_state)
            // Controller has no reset; let any in-flight transfer finish first.
            ST_FLUSH:     if (!i_tft_busy) w_state_nxt = (BOOT_INIT != 0) ? ST_BOOT : ST_IDLE;
            ST_BOOT: begin
                w_boot      = 1'b1;
                w_state_nxt = ST_ISSUE;
            end
            ST_IDLE: if (!w_empty && !i_tft_busy) begin
                w_pop       = 1'b1;
                w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                o_tft_init  = (r_cmd.op == OP_INIT);
                o_tft_draw  = (r_cmd.op == OP_FILL);
                w_state_nxt = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (i_tft_busy) begin
                    w_state_nxt = ST_WAIT_FALL;
                end else if (w_tmr_nxt == TW'(RISE_TMO)) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_FALL: if (!i_tft_busy) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_FLUSH;
        endcase
    end

    assign o_tft_color  = r_cmd.color;
    assign o_tft_xstart = r_cmd.xlo;
    assign o_tft_xend   = r_cmd.xhi;
    assign o_tft_ystart = r_cmd.ylo;
    assign o_tft_yend   = r_cmd.yhi;
    assign o_idle       = (r_state == ST_IDLE) & w_empty;
    assign o_err        = r_err;
endmodule

// File: tb/tb_tft_cmd_queue.sv
// Directed bench for tft_cmd_queue with a behavioural controller model:
// busy rises 2 cycles after a pulse and stays high busy_len cycles.
module tb_tft_cmd_queue;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        tft_busy;
    logic        o_tft_init, o_tft_draw;
    logic [15:0] o_tft_color, o_tft_xstart, o_tft_xend, o_tft_ystart, o_tft_yend;
    logic [4:0]  o_q_level;
    logic        o_idle, o_err;

    logic force_busy = 1'b0;
    logic model_busy = 1'b0;
    logic no_rise    = 1'b0;
    int   busy_len   = 4;
    int   b_len = 0, b_dly = 0;
    int   n_init = 0, n_draw = 0, stab_err = 0;
    int   n_assert = 0, n_fail = 0;
    logic in_txn = 1'b0, seen_busy = 1'b0;
    logic [79:0] cap;
    logic [15:0] draw_col [$];

    tft_cmd_queue_if cmd_if ();

    tft_cmd_queue dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .cmd          (cmd_if),
        .o_tft_init   (o_tft_init),
        .o_tft_draw   (o_tft_draw),
        .o_tft_color  (o_tft_color),
        .o_tft_xstart (o_tft_xstart),
        .o_tft_xend   (o_tft_xend),
        .o_tft_ystart (o_tft_ystart),
        .o_tft_yend   (o_tft_yend),
        .i_tft_busy   (tft_busy),
        .o_q_level    (o_q_level),
        .o_idle       (o_idle),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;
    assign tft_busy = force_busy | model_busy;

    // Controller model plus pulse/param-stability monitor.
    always @(negedge clk) begin
        if (!rstn) in_txn = 1'b0;
        if (o_tft_draw || o_tft_init) begin
            if (o_tft_draw) begin
                n_draw = n_draw + 1;
                draw_col.push_back(o_tft_color);
            end else begin
                n_init = n_init + 1;
            end
            cap       = {o_tft_color, o_tft_xstart, o_tft_xend, o_tft_ystart, o_tft_yend};
            in_txn    = 1'b1;
            seen_busy = 1'b0;
        end else if (in_txn) begin
            if ({o_tft_color, o_tft_xstart, o_tft_xend, o_tft_ystart, o_tft_yend} != cap)
                stab_err = stab_err + 1;
            if (tft_busy) seen_busy = 1'b1;
            else if (seen_busy) in_txn = 1'b0;
        end
        if (b_len > 0) b_len = b_len - 1;
        if (b_dly > 0) begin
            b_dly = b_dly - 1;
            if (b_dly == 0) b_len = busy_len;
        end
        if ((o_tft_draw || o_tft_init) && !no_rise) b_dly = 2;
        model_busy = (b_len > 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic op, input logic [15:0] col, input logic [15:0] x0,
                         input logic [15:0] x1, input logic [15:0] y0, input logic [15:0] y1);
        cmd_if.valid = 1'b1;
        cmd_if.op    = op;
        cmd_if.color = col;
        cmd_if.x0    = x0;
        cmd_if.x1    = x1;
        cmd_if.y0    = y0;
        cmd_if.y1    = y1;
    endtask

    task automatic push_one(input logic [15:0] col, input logic [15:0] x0, input logic [15:0] x1,
                            input logic [15:0] y0, input logic [15:0] y1);
        drive(1'b0, col, x0, x1, y0, y1);
        tick();
        cmd_if.valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (!o_idle && n < max) begin tick(); n++; end
        chk(tag, {31'd0, o_idle}, 32'd1);
    endtask

    task automatic wait_draw(input string tag, input int max);
        int n = 0;
        while (!o_tft_draw && n < max) begin tick(); n++; end
        chk(tag, {31'd0, o_tft_draw}, 32'd1);
    endtask

    initial begin
        int base, n, ni0, nd0;
        cmd_if.valid = 1'b0; cmd_if.op = 1'b0; cmd_if.color = '0;
        cmd_if.x0 = '0; cmd_if.x1 = '0; cmd_if.y0 = '0; cmd_if.y1 = '0;

        // 1: reset values, boot init pulse
        repeat (3) tick();
        chk("rst_ready", {31'd0, cmd_if.ready}, 0);
        chk("rst_init",  {31'd0, o_tft_init}, 0);
        chk("rst_draw",  {31'd0, o_tft_draw}, 0);
        chk("rst_params", {o_tft_xstart, o_tft_color}, 0);
        chk("rst_params2", {o_tft_xend | o_tft_ystart, o_tft_yend}, 0);
        chk("rst_level", 32'(o_q_level), 0);
        chk("rst_idle",  {31'd0, o_idle}, 0);
        chk("rst_err",   {31'd0, o_err}, 0);
        rstn = 1'b1;
        tick(); chk("boot_init_c1", {31'd0, o_tft_init}, 0);
        tick(); chk("boot_init_c2", {31'd0, o_tft_init}, 1);
        tick(); chk("boot_init_off", {31'd0, o_tft_init}, 0);
        chk("boot_not_idle", {31'd0, o_idle}, 0);
        wait_idle("boot_idle", 30);
        chk("boot_one_init", 32'(n_init), 1);

        // 2: basic fill, latency, params
        push_one(16'hF800, 16'd10, 16'd20, 16'd5, 16'd7);
        chk("t2_level1", 32'(o_q_level), 1);
        chk("t2_no_draw_yet", {31'd0, o_tft_draw}, 0);
        tick();
        chk("t2_draw", {31'd0, o_tft_draw}, 1);
        chk("t2_color", 32'(o_tft_color), 32'hF800);
        chk("t2_xs_xe", {o_tft_xstart, o_tft_xend}, {16'd10, 16'd20});
        chk("t2_ys_ye", {o_tft_ystart, o_tft_yend}, {16'd5, 16'd7});
        chk("t2_level0", 32'(o_q_level), 0);
        wait_idle("t2_idle", 40);
        chk("t2_one_draw", 32'(n_draw), 1);

        // 3: swapped + clipped corners, then a 1x1 rectangle
        push_one(16'h001F, 16'd300, 16'd50, 16'd400, 16'd0);
        wait_draw("t3_draw", 10);
        chk("t3_xs_xe", {o_tft_xstart, o_tft_xend}, {16'd50, 16'd239});
        chk("t3_ys_ye", {o_tft_ystart, o_tft_yend}, {16'd0, 16'd319});
        wait_idle("t3_idle", 40);
        push_one(16'h07E0, 16'd7, 16'd7, 16'd9, 16'd9);
        wait_draw("t3b_draw", 10);
        chk("t3b_xs_xe", {o_tft_xstart, o_tft_xend}, {16'd7, 16'd7});
        chk("t3b_ys_ye", {o_tft_ystart, o_tft_yend}, {16'd9, 16'd9});
        wait_idle("t3b_idle", 40);

        // 4: fill queue while busy, check full, drain in order
        force_busy = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 16'h1000 + 16'(i), 16'(i), 16'(i + 1), 16'(2 * i), 16'd0);
            tick();
        end
        drive(1'b0, 16'h1010, 16'd1, 16'd2, 16'd3, 16'd4);
        chk("t4_full_ready", {31'd0, cmd_if.ready}, 0);
        chk("t4_full_level", 32'(o_q_level), 16);
        tick();
        chk("t4_17th_rejected", 32'(o_q_level), 16);
        cmd_if.valid = 1'b0;
        draw_col.delete();
        base = n_draw;
        busy_len = 3;
        force_busy = 1'b0;
        n = 0;
        while (n_draw < base + 16 && n < 600) begin tick(); n++; end
        wait_idle("t4_drain_idle", 40);
        chk("t4_draw_count", 32'(draw_col.size()), 16);
        for (int i = 0; i < 16; i++)
            if (i < draw_col.size()) chk($sformatf("t4_color%0d", i), 32'(draw_col[i]), 32'h1000 + 32'(i));

        // 4b: push and pop in the same cycle
        base = n_draw;
        force_busy = 1'b1;
        tick();
        push_one(16'hAAAA, 16'd1, 16'd2, 16'd3, 16'd4);
        chk("t4b_level_a", 32'(o_q_level), 1);
        force_busy = 1'b0;
        drive(1'b0, 16'hBBBB, 16'd5, 16'd6, 16'd7, 16'd8);
        tick();
        cmd_if.valid = 1'b0;
        chk("t4b_level_same", 32'(o_q_level), 1);
        chk("t4b_draw_a", {15'd0, o_tft_draw, o_tft_color}, {16'd1, 16'hAAAA});
        wait_idle("t4b_idle", 60);
        chk("t4b_two_draws", 32'(n_draw - base), 2);

        // 5: reset in WAIT_FALL with busy held high
        busy_len = 10;
        push_one(16'h0E0E, 16'd1, 16'd1, 16'd1, 16'd1);
        wait_draw("t5_draw", 10);
        drive(1'b0, 16'h0F0F, 16'd2, 16'd2, 16'd2, 16'd2);
        tick();
        drive(1'b0, 16'h0C0C, 16'd3, 16'd3, 16'd3, 16'd3);
        tick();
        cmd_if.valid = 1'b0;
        tick();
        chk("t5_queued", 32'(o_q_level), 2);
        tick();
        force_busy = 1'b1;
        rstn = 1'b0;
        tick();
        chk("t5_rst_level", 32'(o_q_level), 0);
        chk("t5_rst_pulses", {30'd0, o_tft_init, o_tft_draw}, 0);
        chk("t5_rst_ready", {31'd0, cmd_if.ready}, 0);
        tick();
        rstn = 1'b1;
        ni0 = n_init;
        nd0 = n_draw;
        repeat (50) tick();
        chk("t5_no_init_busy", 32'(n_init), 32'(ni0));
        chk("t5_no_draw_busy", 32'(n_draw), 32'(nd0));
        chk("t5_flush_not_idle", {31'd0, o_idle}, 0);
        force_busy = 1'b0;
        tick(); chk("t5_boot_c1", {31'd0, o_tft_init}, 0);
        tick(); chk("t5_boot_c2", {31'd0, o_tft_init}, 1);
        wait_idle("t5_idle", 40);
        chk("t5_one_init", 32'(n_init - ni0), 1);
        chk("t5_queue_dropped", 32'(n_draw - nd0), 0);

        // 6: busy never rises -> sticky err, next command still issues
        busy_len = 3;
        no_rise = 1'b1;
        drive(1'b0, 16'h0C0C, 16'd1, 16'd2, 16'd1, 16'd2);
        tick();
        drive(1'b0, 16'h0D0D, 16'd3, 16'd4, 16'd3, 16'd4);
        tick();
        cmd_if.valid = 1'b0;
        chk("t6_draw_c", {15'd0, o_tft_draw, o_tft_color}, {16'd1, 16'h0C0C});
        repeat (7) tick();
        chk("t6_err_before", {31'd0, o_err}, 0);
        tick();
        chk("t6_err_set", {31'd0, o_err}, 1);
        no_rise = 1'b0;
        tick();
        chk("t6_draw_d", {15'd0, o_tft_draw, o_tft_color}, {16'd1, 16'h0D0D});
        wait_idle("t6_idle", 40);
        chk("t6_err_sticky", {31'd0, o_err}, 1);
        chk("param_stability", 32'(stab_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
